// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter for the MEM stage.
// Shares one single-port synchronous memory between the pipeline load/store port and the
// debug read port. Sub-word stores are done as read-modify-write. Loads are sign- or
// zero-extended. The pipeline is stalled while an access is in flight.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to suppress misaligned pipeline accesses
// and raise a sticky o_misalign flag.
module dmem_port_arbiter #(
  parameter int unsigned DU_STARVE_MAX = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pl_mem_read,
  input  logic        i_pl_mem_write,
  input  logic [31:0] i_pl_addr,
  input  logic [31:0] i_pl_wdata,
  input  logic [2:0]  i_pl_bhw_type,
  output logic        o_pl_stall,
  output logic [31:0] o_pl_rdata,
  output logic        o_pl_rvalid,
  input  logic        i_du_req,
  input  logic [31:0] i_du_addr,
  output logic [31:0] o_du_rdata,
  output logic        o_du_ack,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_misalign
);

  typedef enum logic [1:0] {StIdle, StLdWait, StStMerge, StDuWait} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q;
  logic [2:0]         type_q;
  logic [31:0]        du_rdata_q;
  logic               ack_q;

  logic        is_rd, is_wr, ld_ok, st_ok, pl_req;
  logic        ty_word, ty_half, misalign_now;
  logic        du_pending, cnt_at_max, du_grant;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, merged;
  logic        unused_du_lsb;

  // Word alignment of the debug address discards its two low bits.
  assign unused_du_lsb = ^i_du_addr[1:0];

  // A simultaneous read and write is treated as a read only.
  assign is_rd   = i_pl_mem_read;
  assign is_wr   = i_pl_mem_write & ~i_pl_mem_read;
  assign ld_ok   = is_rd && (i_pl_bhw_type != 3'b000) && (i_pl_bhw_type != 3'b011);
  assign st_ok   = is_wr && ((i_pl_bhw_type == 3'b001) || (i_pl_bhw_type == 3'b010) ||
                             (i_pl_bhw_type == 3'b100));
  assign pl_req  = ld_ok | st_ok;
  assign ty_word = (i_pl_bhw_type == 3'b001) || (i_pl_bhw_type == 3'b101);
  assign ty_half = (i_pl_bhw_type == 3'b010) || (i_pl_bhw_type == 3'b111);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_now = (ty_word && (i_pl_addr[1:0] != 2'b00)) || (ty_half && i_pl_addr[0]);
`else
  assign misalign_now = 1'b0;
`endif

  // The request being acknowledged this cycle is already served; do not grant it again.
  assign du_pending = i_du_req & ~ack_q;
  assign cnt_at_max = (cnt_q == CNT_W'(DU_STARVE_MAX));
  assign du_grant   = du_pending && (!pl_req || cnt_at_max);

  // Load lane selection and extension from the captured type and offset.
  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_q[1:0])
      2'd0: ld_byte = i_mem_rdata[7:0];
      2'd1: ld_byte = i_mem_rdata[15:8];
      2'd2: ld_byte = i_mem_rdata[23:16];
      2'd3: ld_byte = i_mem_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (type_q)
      3'b100:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b110:  ld_data = {24'h0, ld_byte};
      3'b010:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b111:  ld_data = {16'h0, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  // Sub-word store merge: replace the addressed lane of the word just read.
  always_comb begin
    merged = i_mem_rdata;
    if (type_q == 3'b100) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = i_pl_wdata[7:0];
        2'd1: merged[15:8]  = i_pl_wdata[7:0];
        2'd2: merged[23:16] = i_pl_wdata[7:0];
        2'd3: merged[31:24] = i_pl_wdata[7:0];
        default: merged = i_mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = i_pl_wdata[15:0];
    end else begin
      merged[15:0] = i_pl_wdata[15:0];
    end
  end

  // Next-state, memory strobes and pipeline handshake.
  always_comb begin
    state_d     = state_q;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = {i_pl_addr[31:2], 2'b00};
    o_mem_wdata = i_pl_wdata;
    o_pl_stall  = 1'b0;
    o_pl_rvalid = 1'b0;
    o_pl_rdata  = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (du_grant) begin
          o_mem_en   = 1'b1;
          o_mem_addr = {i_du_addr[31:2], 2'b00};
          o_pl_stall = pl_req;
          state_d    = StDuWait;
        end else if (pl_req) begin
          if (misalign_now) begin
            // Suppressed access: a load completes at once with zero data.
            o_pl_rvalid = ld_ok;
          end else if (ld_ok) begin
            o_mem_en   = 1'b1;
            o_pl_stall = 1'b1;
            state_d    = StLdWait;
          end else if (i_pl_bhw_type == 3'b001) begin
            o_mem_en = 1'b1;
            o_mem_we = 1'b1;
          end else begin
            o_mem_en   = 1'b1;
            o_pl_stall = 1'b1;
            state_d    = StStMerge;
          end
        end
      end
      StLdWait: begin
        o_pl_rvalid = 1'b1;
        o_pl_rdata  = ld_data;
        state_d     = StIdle;
      end
      StStMerge: begin
        o_mem_en    = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {addr_q[31:2], 2'b00};
        o_mem_wdata = merged;
        state_d     = StIdle;
      end
      StDuWait: begin
        o_pl_stall = pl_req;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Nothing reaches the memory or the pipeline while reset is held.
    if (!i_reset) begin
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_pl_stall  = 1'b0;
      o_pl_rvalid = 1'b0;
      o_pl_rdata  = 32'h0;
    end
  end

  // Debug starvation counter: counts blocked IDLE cycles, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (!du_pending) begin
      cnt_d = '0;
    end else if (state_q == StIdle) begin
      if (du_grant) begin
        cnt_d = '0;
      end else if (!cnt_at_max) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, captured request and debug read registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= 32'h0;
      type_q     <= 3'b000;
      du_rdata_q <= 32'h0;
      ack_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_q == StDuWait);
      if (state_q == StIdle) begin
        addr_q <= i_pl_addr;
        type_q <= i_pl_bhw_type;
      end
      if (state_q == StDuWait) begin
        du_rdata_q <= i_mem_rdata;
      end
    end
  end

  assign o_du_rdata = du_rdata_q;
  assign o_du_ack   = ack_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;

  // Sticky flag, set when a misaligned pipeline access is taken in IDLE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      misalign_q <= 1'b0;
    end else if ((state_q == StIdle) && !du_grant && pl_req && misalign_now) begin
      misalign_q <= 1'b1;
    end
  end

  assign o_misalign = misalign_q;
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: per-cycle vector table plus reset/misalign sequences.
module tb_dmem_port_arbiter;

  logic        clk, rst_n;
  logic        pl_rd, pl_wr;
  logic [31:0] pl_addr, pl_wdata;
  logic [2:0]  pl_bhw;
  logic        pl_stall, pl_rvalid;
  logic [31:0] pl_rdata;
  logic        du_req, du_ack;
  logic [31:0] du_addr, du_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  dmem_port_arbiter #(.DU_STARVE_MAX(4), .CNT_W(3)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_pl_mem_read (pl_rd),
    .i_pl_mem_write(pl_wr),
    .i_pl_addr     (pl_addr),
    .i_pl_wdata    (pl_wdata),
    .i_pl_bhw_type (pl_bhw),
    .o_pl_stall    (pl_stall),
    .o_pl_rdata    (pl_rdata),
    .o_pl_rvalid   (pl_rvalid),
    .i_du_req      (du_req),
    .i_du_addr     (du_addr),
    .o_du_rdata    (du_rdata),
    .o_du_ack      (du_ack),
    .o_mem_en      (mem_en),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata),
    .o_misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  bhw;
    logic [31:0] addr, wdata;
    logic        du;
    logic [31:0] du_addr, mrd;
    logic        stall, en, we;
    logic [31:0] maddr, mwdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ack;
    logic [31:0] dur;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] bhw,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic du, input logic [31:0] dadr, input logic [31:0] mrd,
                              input logic stall, input logic en, input logic we,
                              input logic [31:0] maddr, input logic [31:0] mwdata,
                              input logic rvalid, input logic [31:0] rdata,
                              input logic ack, input logic [31:0] dur);
    vec_t v;
    v.rd = rd; v.wr = wr; v.bhw = bhw; v.addr = addr; v.wdata = wdata;
    v.du = du; v.du_addr = dadr; v.mrd = mrd;
    v.stall = stall; v.en = en; v.we = we; v.maddr = maddr; v.mwdata = mwdata;
    v.rvalid = rvalid; v.rdata = rdata; v.ack = ack; v.dur = dur;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] bhw,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic du,
                       input logic [31:0] dadr, input logic [31:0] mrd);
    pl_rd = rd; pl_wr = wr; pl_bhw = bhw; pl_addr = addr; pl_wdata = wdata;
    du_req = du; du_addr = dadr; mem_rdata = mrd;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Per-cycle vectors: inputs, then expected stall/en/we/addr/wdata/rvalid/rdata/ack/du_rdata.
    vecs.push_back(mk(0,0,3'b000,32'h0 ,32'h0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0,0,32'h0,0,32'h0));
    // LB / LBU / LH / LHU / LB lane 3 from word 0x8000_F0A5
    vecs.push_back(mk(1,0,3'b100,32'h10,32'h0,0,32'h0,32'h0, 1,1,0,32'h10,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b100,32'h10,32'h0,0,32'h0,32'h8000F0A5,
                      0,0,0,32'h0,32'h0,1,32'hFFFFFFA5,0,32'h0));
    vecs.push_back(mk(1,0,3'b110,32'h10,32'h0,0,32'h0,32'h0, 1,1,0,32'h10,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b110,32'h10,32'h0,0,32'h0,32'h8000F0A5,
                      0,0,0,32'h0,32'h0,1,32'h000000A5,0,32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h12,32'h0,0,32'h0,32'h0, 1,1,0,32'h10,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h12,32'h0,0,32'h0,32'h8000F0A5,
                      0,0,0,32'h0,32'h0,1,32'hFFFF8000,0,32'h0));
    vecs.push_back(mk(1,0,3'b111,32'h10,32'h0,0,32'h0,32'h0, 1,1,0,32'h10,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b111,32'h10,32'h0,0,32'h0,32'h8000F0A5,
                      0,0,0,32'h0,32'h0,1,32'h0000F0A5,0,32'h0));
    vecs.push_back(mk(1,0,3'b100,32'h13,32'h0,0,32'h0,32'h0, 1,1,0,32'h10,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b100,32'h13,32'h0,0,32'h0,32'h8000F0A5,
                      0,0,0,32'h0,32'h0,1,32'hFFFFFF80,0,32'h0));
    // SB 0xEE to 0x21 and SH 0xABCD to 0x22 over word 0x1122_3344
    vecs.push_back(mk(0,1,3'b100,32'h21,32'h123456EE,0,32'h0,32'h0,
                      1,1,0,32'h20,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,3'b100,32'h21,32'h123456EE,0,32'h0,32'h11223344,
                      0,1,1,32'h20,32'h1122EE44,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,3'b010,32'h22,32'hFFFFABCD,0,32'h0,32'h0,
                      1,1,0,32'h20,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,3'b010,32'h22,32'hFFFFABCD,0,32'h0,32'h11223344,
                      0,1,1,32'h20,32'hABCD3344,0,32'h0,0,32'h0));
    // SW then debug read of the same word
    vecs.push_back(mk(0,1,3'b001,32'h30,32'hDEADBEEF,0,32'h0,32'h0,
                      0,1,1,32'h30,32'hDEADBEEF,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,0,3'b000,32'h0,32'h0,1,32'h32,32'h0, 0,1,0,32'h30,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,0,3'b000,32'h0,32'h0,1,32'h32,32'hDEADBEEF,
                      0,0,0,32'h0,32'h0,0,32'h0,0,32'h0));
    vecs.push_back(mk(0,0,3'b000,32'h0,32'h0,1,32'h32,32'h0,
                      0,0,0,32'h0,32'h0,0,32'h0,1,32'hDEADBEEF));
    vecs.push_back(mk(0,0,3'b000,32'h0,32'h0,0,32'h0,32'h0,
                      0,0,0,32'h0,32'h0,0,32'h0,0,32'hDEADBEEF));
    // Unlisted type: no access, no stall; then read+write together acts as LW
    vecs.push_back(mk(1,0,3'b011,32'h40,32'h0,0,32'h0,32'h0,
                      0,0,0,32'h0,32'h0,0,32'h0,0,32'hDEADBEEF));
    vecs.push_back(mk(1,1,3'b001,32'h44,32'h99,0,32'h0,32'h0,
                      1,1,0,32'h44,32'h0,0,32'h0,0,32'hDEADBEEF));
    vecs.push_back(mk(1,1,3'b001,32'h44,32'h99,0,32'h0,32'h55AA55AA,
                      0,0,0,32'h0,32'h0,1,32'h55AA55AA,0,32'hDEADBEEF));
    // Debug starved by back-to-back LW; forced through on the 5th IDLE cycle
    vecs.push_back(mk(1,0,3'b001,32'h50,32'h0,1,32'h60,32'h0,
                      1,1,0,32'h50,32'h0,0,32'h0,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h50,32'h0,1,32'h60,32'h1,
                      0,0,0,32'h0,32'h0,1,32'h1,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h54,32'h0,1,32'h60,32'h0,
                      1,1,0,32'h54,32'h0,0,32'h0,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h54,32'h0,1,32'h60,32'h2,
                      0,0,0,32'h0,32'h0,1,32'h2,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h58,32'h0,1,32'h60,32'h0,
                      1,1,0,32'h58,32'h0,0,32'h0,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h58,32'h0,1,32'h60,32'h3,
                      0,0,0,32'h0,32'h0,1,32'h3,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h5C,32'h0,1,32'h60,32'h0,
                      1,1,0,32'h5C,32'h0,0,32'h0,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h5C,32'h0,1,32'h60,32'h4,
                      0,0,0,32'h0,32'h0,1,32'h4,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h50,32'h0,1,32'h60,32'h0,
                      1,1,0,32'h60,32'h0,0,32'h0,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h50,32'h0,1,32'h60,32'hCAFEF00D,
                      1,0,0,32'h0,32'h0,0,32'h0,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b001,32'h50,32'h0,1,32'h60,32'h0,
                      1,1,0,32'h50,32'h0,0,32'h0,1,32'hCAFEF00D));
    vecs.push_back(mk(1,0,3'b001,32'h50,32'h0,0,32'h0,32'h7,
                      0,0,0,32'h0,32'h0,1,32'h7,0,32'hCAFEF00D));

    // Reset: requests present but nothing may reach memory or the pipeline
    rst_n = 1'b1;
    drive(1, 0, 3'b001, 32'h10, 32'h0, 1, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.en", {31'h0, mem_en}, 32'h0);
    chk("rst.we", {31'h0, mem_we}, 32'h0);
    chk("rst.stall", {31'h0, pl_stall}, 32'h0);
    chk("rst.rvalid", {31'h0, pl_rvalid}, 32'h0);
    chk("rst.ack", {31'h0, du_ack}, 32'h0);
    chk("rst.du_rdata", du_rdata, 32'h0);
    chk("rst.misalign", {31'h0, misalign}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].bhw, vecs[i].addr, vecs[i].wdata,
            vecs[i].du, vecs[i].du_addr, vecs[i].mrd);
      #2;
      chk($sformatf("v%0d.stall", i), {31'h0, pl_stall}, {31'h0, vecs[i].stall});
      chk($sformatf("v%0d.en", i), {31'h0, mem_en}, {31'h0, vecs[i].en});
      chk($sformatf("v%0d.we", i), {31'h0, mem_we}, {31'h0, vecs[i].we});
      if (vecs[i].en) chk($sformatf("v%0d.maddr", i), mem_addr, vecs[i].maddr);
      if (vecs[i].we) chk($sformatf("v%0d.mwdata", i), mem_wdata, vecs[i].mwdata);
      chk($sformatf("v%0d.rvalid", i), {31'h0, pl_rvalid}, {31'h0, vecs[i].rvalid});
      chk($sformatf("v%0d.rdata", i), pl_rdata, vecs[i].rdata);
      chk($sformatf("v%0d.ack", i), {31'h0, du_ack}, {31'h0, vecs[i].ack});
      chk($sformatf("v%0d.du_rdata", i), du_rdata, vecs[i].dur);
      @(posedge clk); #1;
    end

    // Reset during LD_WAIT abandons the load; the held request restarts from IDLE
    drive(1, 0, 3'b001, 32'h70, 32'h0, 0, 32'h0, 32'h0);
    #2 chk("ldrst.pre_en", {31'h0, mem_en}, 32'h1);
    @(posedge clk); #1;
    drive(1, 0, 3'b001, 32'h70, 32'h0, 0, 32'h0, 32'h12345678);
    #1 chk("ldrst.wait_rvalid", {31'h0, pl_rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ldrst.rvalid", {31'h0, pl_rvalid}, 32'h0);
    chk("ldrst.rdata", pl_rdata, 32'h0);
    chk("ldrst.stall", {31'h0, pl_stall}, 32'h0);
    chk("ldrst.en", {31'h0, mem_en}, 32'h0);
    chk("ldrst.du_rdata", du_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    chk("ldrst.idle_en", {31'h0, mem_en}, 32'h1);
    chk("ldrst.idle_stall", {31'h0, pl_stall}, 32'h1);
    chk("ldrst.idle_rvalid", {31'h0, pl_rvalid}, 32'h0);
    @(posedge clk); #1;
    drive(1, 0, 3'b001, 32'h70, 32'h0, 0, 32'h0, 32'h0BADF00D);
    #2 chk("ldrst.reload", pl_rdata, 32'h0BADF00D);
    @(posedge clk); #1;

    // Reset during ST_MERGE: the pending write is dropped
    drive(0, 1, 3'b100, 32'h80, 32'hEE, 0, 32'h0, 32'h0);
    #2 chk("strst.pre_stall", {31'h0, pl_stall}, 32'h1);
    @(posedge clk); #1;
    chk("strst.merge_we", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("strst.en", {31'h0, mem_en}, 32'h0);
    chk("strst.we", {31'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    chk("strst.after_we", {31'h0, mem_we}, 32'h0);
    chk("strst.after_stall", {31'h0, pl_stall}, 32'h1);
    @(posedge clk); #1;
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misaligned LW: no access, immediate zero data, sticky flag
    drive(1, 0, 3'b001, 32'h41, 32'h0, 0, 32'h0, 32'hFFFFFFFF);
    #2;
    chk("mis.en", {31'h0, mem_en}, 32'h0);
    chk("mis.stall", {31'h0, pl_stall}, 32'h0);
    chk("mis.rvalid", {31'h0, pl_rvalid}, 32'h1);
    chk("mis.rdata", pl_rdata, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    #2 chk("mis.flag", {31'h0, misalign}, 32'h1);
    @(posedge clk); #1;
    chk("mis.held", {31'h0, misalign}, 32'h1);
    rst_n = 1'b0;
    #1 chk("mis.rst", {31'h0, misalign}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`else
    // Without the trap a misaligned LW is a normal word access
    drive(1, 0, 3'b001, 32'h41, 32'h0, 0, 32'h0, 32'h0);
    #2;
    chk("mis.en", {31'h0, mem_en}, 32'h1);
    chk("mis.maddr", mem_addr, 32'h40);
    chk("mis.stall", {31'h0, pl_stall}, 32'h1);
    @(posedge clk); #1;
    drive(1, 0, 3'b001, 32'h41, 32'h0, 0, 32'h0, 32'hA5A5A5A5);
    #2;
    chk("mis.rdata", pl_rdata, 32'hA5A5A5A5);
    chk("mis.flag", {31'h0, misalign}, 32'h0);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
